packet_fragmenter_axis: RTL and testbench

PACKET_FRAGMENTER_AXIS -- requirements
Module: packet_fragmenter_axis

---
 rtl/packet_fragmenter_axis.sv | 202 ++++++++++++++++++++
 tb/tb_packet_fragmenter_axis.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_fragmenter_axis.sv
// Splits each triggered AXI-Stream transfer into fragments of mss beats separated by ifg idle cycles.
// Define PACKET_FRAGMENTER_STATS_EN to build the frag_count/xfer_count statistics counters.
module packet_fragmenter_axis #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  trigger,
    input  logic                  continuous,
    input  logic [CNT_WIDTH-1:0]  mss,
    input  logic [CNT_WIDTH-1:0]  ifg,
    input  logic [CNT_WIDTH-1:0]  transfer_size,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frag_count,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        WAIT_TRIGGER,
        SEND,
        GAP
    } state_t;

    state_t                state_q, state_d;
    logic                  trigger_q;
    logic [CNT_WIDTH-1:0]  mss_q, mss_d;
    logic [CNT_WIDTH-1:0]  ifg_q, ifg_d;
    logic [CNT_WIDTH-1:0]  size_q, size_d;
    logic [CNT_WIDTH-1:0]  beatInFrag_q, beatInFrag_d;
    logic [CNT_WIDTH-1:0]  beatInXfer_q, beatInXfer_d;
    logic [CNT_WIDTH-1:0]  gapCnt_q, gapCnt_d;
    logic [DATA_WIDTH-1:0] mData_q, mData_d;
    logic                  mValid_q, mValid_d;
    logic                  mLast_q, mLast_d;
    logic [USER_WIDTH-1:0] mUser_q, mUser_d;

    logic trigEdge;
    logic sliceFree;
    logic accept;
    logic fragEnd;
    logic xferEnd;

    // Framing is driven purely by mss/transfer_size, so the upstream tlast is deliberately dropped.
    logic unusedTlast;
    assign unusedTlast = s_axis_tlast;

    assign trigEdge      = trigger & ~trigger_q;
    assign sliceFree     = ~mValid_q | m_axis_tready;
    assign s_axis_tready = (state_q == SEND) & sliceFree;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign fragEnd       = (beatInFrag_q == mss_q - CNT_WIDTH'(1));
    assign xferEnd       = (beatInXfer_q == size_q - CNT_WIDTH'(1));

    assign busy          = (state_q != WAIT_TRIGGER);
    assign m_axis_tdata  = mData_q;
    assign m_axis_tvalid = mValid_q;
    assign m_axis_tlast  = mLast_q;
    assign m_axis_tuser  = mUser_q;

    always_comb begin
        state_d      = state_q;
        mss_d        = mss_q;
        ifg_d        = ifg_q;
        size_d       = size_q;
        beatInFrag_d = beatInFrag_q;
        beatInXfer_d = beatInXfer_q;
        gapCnt_d     = gapCnt_q;
        mData_d      = mData_q;
        mValid_d     = mValid_q;
        mLast_d      = mLast_q;
        mUser_d      = mUser_q;

        case (state_q)
            WAIT_TRIGGER: begin
                if ((trigEdge | continuous) && (transfer_size != '0)) begin
                    mss_d        = (mss == '0) ? CNT_WIDTH'(1) : mss;
                    ifg_d        = ifg;
                    size_d       = transfer_size;
                    beatInFrag_d = '0;
                    beatInXfer_d = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (xferEnd) begin
                        beatInFrag_d = '0;
                        beatInXfer_d = '0;
                        state_d      = WAIT_TRIGGER;
                    end else if (fragEnd) begin
                        beatInFrag_d = '0;
                        beatInXfer_d = beatInXfer_q + CNT_WIDTH'(1);
                        if (ifg_q != '0) begin
                            gapCnt_d = '0;
                            state_d  = GAP;
                        end
                    end else begin
                        beatInFrag_d = beatInFrag_q + CNT_WIDTH'(1);
                        beatInXfer_d = beatInXfer_q + CNT_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                if (gapCnt_q == ifg_q - CNT_WIDTH'(1)) begin
                    state_d = SEND;
                end else begin
                    gapCnt_d = gapCnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = WAIT_TRIGGER;
        endcase

        // The output slice either takes the new beat or empties to all-zero once its beat is consumed.
        if (sliceFree) begin
            if (accept) begin
                mData_d  = s_axis_tdata;
                mValid_d = 1'b1;
                mLast_d  = fragEnd | xferEnd;
                mUser_d  = s_axis_tuser;
            end else begin
                mData_d  = '0;
                mValid_d = 1'b0;
                mLast_d  = 1'b0;
                mUser_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q      <= WAIT_TRIGGER;
            trigger_q    <= 1'b0;
            mss_q        <= '0;
            ifg_q        <= '0;
            size_q       <= '0;
            beatInFrag_q <= '0;
            beatInXfer_q <= '0;
            gapCnt_q     <= '0;
            mData_q      <= '0;
            mValid_q     <= 1'b0;
            mLast_q      <= 1'b0;
            mUser_q      <= '0;
        end else begin
            state_q      <= state_d;
            trigger_q    <= trigger;
            mss_q        <= mss_d;
            ifg_q        <= ifg_d;
            size_q       <= size_d;
            beatInFrag_q <= beatInFrag_d;
            beatInXfer_q <= beatInXfer_d;
            gapCnt_q     <= gapCnt_d;
            mData_q      <= mData_d;
            mValid_q     <= mValid_d;
            mLast_q      <= mLast_d;
            mUser_q      <= mUser_d;
        end
    end

`ifdef PACKET_FRAGMENTER_STATS_EN
    logic                 xferLast_q;
    logic [CNT_WIDTH-1:0] fragCount_q;
    logic [CNT_WIDTH-1:0] xferCount_q;

    // Statistics count beats as they leave on m_axis, so a beat discarded by reset is never counted.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            xferLast_q  <= 1'b0;
            fragCount_q <= '0;
            xferCount_q <= '0;
        end else begin
            if (sliceFree) begin
                xferLast_q <= accept & xferEnd;
            end
            if (mValid_q & m_axis_tready & mLast_q) begin
                fragCount_q <= fragCount_q + CNT_WIDTH'(1);
            end
            if (mValid_q & m_axis_tready & xferLast_q) begin
                xferCount_q <= xferCount_q + CNT_WIDTH'(1);
            end
        end
    end

    assign frag_count = fragCount_q;
    assign xfer_count = xferCount_q;
`else
    assign frag_count = '0;
    assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_packet_fragmenter_axis.sv
// Self-checking bench for packet_fragmenter_axis: a transfer-level model predicts every output beat,
// tlast position and inter-fragment gap; directed scenarios cover backpressure, edge cases and reset.
module tb_packet_fragmenter_axis;

    localparam int DW = 64;
    localparam int CW = 32;
    localparam int UW = 1;

    logic          clk = 1'b0;
    logic          arst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [UW-1:0] s_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser;
    logic          trigger;
    logic          continuous;
    logic [CW-1:0] mss;
    logic [CW-1:0] ifg;
    logic [CW-1:0] transfer_size;
    logic          busy;
    logic [CW-1:0] frag_count;
    logic [CW-1:0] xfer_count;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            idle;
    } beat_t;

    beat_t         expQ[$];
    int            total = 0;
    int            bad = 0;
    bit            compEn = 1'b0;
    bit            gapCheck = 1'b0;
    int            idleCount = 0;
    bit            prevStall = 1'b0;
    logic [DW-1:0] prevData = '0;
    int            outBeats = 0;
    logic [DW-1:0] srcData;
    bit            readyToggle = 1'b0;

    packet_fragmenter_axis #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .USER_WIDTH(UW)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .trigger      (trigger),
        .continuous   (continuous),
        .mss          (mss),
        .ifg          (ifg),
        .transfer_size(transfer_size),
        .busy         (busy),
        .frag_count   (frag_count),
        .xfer_count   (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected beats of one transfer: consecutive source words, tlast at each mss boundary or the end,
    // and ifg idle output cycles in front of every fragment after the first.
    task automatic planTransfer(input int mssIn, input int ifgIn, input int size, input logic [DW-1:0] start);
        int    m;
        beat_t b;
        m = (mssIn == 0) ? 1 : mssIn;
        for (int i = 0; i < size; i++) begin
            b.data = start + DW'(i);
            b.last = ((i % m) == m - 1) || (i == size - 1);
            b.idle = (i == 0) ? -1 : (((i % m) == 0) ? ifgIn : 0);
            expQ.push_back(b);
        end
    endtask

    task automatic applyStimulus(input int mssIn, input int ifgIn, input int size);
        mss           = CW'(mssIn);
        ifg           = CW'(ifgIn);
        transfer_size = CW'(size);
        @(posedge clk);
        #1 trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    task automatic waitDone(input string name, input int maxCycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((expQ.size() == 0) && !busy && !m_axis_tvalid) && (n < maxCycles));
        checkOutput({name, "_finished"}, 64'((expQ.size() == 0) && !busy && !m_axis_tvalid), 64'd1);
    endtask

    task automatic watchIdle(input string name, input int cycles);
        bit sawBusy;
        bit sawValid;
        sawBusy  = 1'b0;
        sawValid = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            sawBusy  = sawBusy | busy;
            sawValid = sawValid | m_axis_tvalid;
        end
        checkOutput({name, "_busy"}, 64'(sawBusy), 64'd0);
        checkOutput({name, "_valid"}, 64'(sawValid), 64'd0);
    endtask

    // Source: presents srcData continuously and advances only after a beat is actually taken.
    initial begin
        bit hs;
        srcData       = 64'h100;
        s_axis_tdata  = srcData;
        s_axis_tuser  = srcData[0];
        s_axis_tlast  = srcData[1];
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (hs && arst) begin
                srcData      = srcData + 64'd1;
                s_axis_tdata = srcData;
                s_axis_tuser = srcData[0];
                s_axis_tlast = srcData[1];
            end
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m_axis_tready = readyToggle ? ~m_axis_tready : 1'b1;
        end
    end

    // Compare process: every output handshake is matched against the model, stalls must hold data,
    // and an empty slot must present all-zero data.
    always @(negedge clk) begin
        if (compEn) begin
            if (m_axis_tvalid) begin
                if (prevStall) begin
                    checkOutput("stallHold", m_axis_tdata, prevData);
                end
                if (m_axis_tready) begin
                    outBeats++;
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpectedBeat actual=%0h required=none", m_axis_tdata);
                    end else begin
                        beat_t e;
                        e = expQ.pop_front();
                        checkOutput("beatData", m_axis_tdata, e.data);
                        checkOutput("beatLast", 64'(m_axis_tlast), 64'(e.last));
                        checkOutput("beatUser", 64'(m_axis_tuser), 64'(e.data[0]));
                        if (gapCheck && (e.idle >= 0)) begin
                            checkOutput("idleGap", 64'(idleCount), 64'(e.idle));
                        end
                    end
                    idleCount = 0;
                end
            end else begin
                checkOutput("idleData", m_axis_tdata, 64'd0);
                idleCount++;
            end
            prevStall = m_axis_tvalid & ~m_axis_tready;
            prevData  = m_axis_tdata;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int        base;
        int        n;
        logic [9:0] lastMask;

        arst          = 1'b0;
        trigger       = 1'b0;
        continuous    = 1'b0;
        mss           = CW'(4);
        ifg           = CW'(3);
        transfer_size = CW'(10);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rstValid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("rstData", m_axis_tdata, 64'd0);
        checkOutput("rstLast", 64'(m_axis_tlast), 64'd0);
        checkOutput("rstUser", 64'(m_axis_tuser), 64'd0);
        checkOutput("rstReady", 64'(s_axis_tready), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstFrag", 64'(frag_count), 64'd0);
        checkOutput("rstXfer", 64'(xfer_count), 64'd0);

        @(negedge clk);
        arst = 1'b1;
        repeat (2) @(negedge clk);
        compEn = 1'b1;

        $display("[TB] basic 4/3/10 transfer");
        gapCheck = 1'b1;
        planTransfer(4, 3, 10, srcData);
        lastMask = '0;
        for (int i = 0; i < 10; i++) lastMask[i] = expQ[i].last;
        checkOutput("modelCount", 64'(expQ.size()), 64'd10);
        checkOutput("modelLasts", 64'(lastMask), 64'h288);
        checkOutput("modelGap", 64'(expQ[4].idle), 64'd3);
        base = outBeats;
        applyStimulus(4, 3, 10);
        @(negedge clk);
        checkOutput("busyHigh", 64'(busy), 64'd1);
        waitDone("basic", 200);
        checkOutput("basicBeats", 64'(outBeats - base), 64'd10);
`ifdef PACKET_FRAGMENTER_STATS_EN
        checkOutput("statFrag", 64'(frag_count), 64'd3);
        checkOutput("statXfer", 64'(xfer_count), 64'd1);
`else
        checkOutput("statFrag", 64'(frag_count), 64'd0);
        checkOutput("statXfer", 64'(xfer_count), 64'd0);
`endif

        $display("[TB] toggling backpressure");
        gapCheck = 1'b0;
        readyToggle = 1'b1;
        planTransfer(4, 3, 10, srcData);
        base = outBeats;
        applyStimulus(4, 3, 10);
        waitDone("toggle", 400);
        checkOutput("toggleBeats", 64'(outBeats - base), 64'd10);
        readyToggle = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] mss=0, ifg=0, size=3 then size=0");
        gapCheck = 1'b1;
        planTransfer(0, 0, 3, srcData);
        base = outBeats;
        applyStimulus(0, 0, 3);
        waitDone("mssZero", 100);
        checkOutput("mssZeroBeats", 64'(outBeats - base), 64'd3);
        applyStimulus(0, 0, 0);
        watchIdle("sizeZero", 8);

        $display("[TB] mid-transfer trigger and mss change");
        planTransfer(4, 1, 10, srcData);
        base = outBeats;
        applyStimulus(4, 1, 10);
        repeat (3) @(negedge clk);
        applyStimulus(2, 0, 3);
        waitDone("midChange", 200);
        checkOutput("midChangeBeats", 64'(outBeats - base), 64'd10);
        watchIdle("noQueuedEdge", 6);

        $display("[TB] continuous re-arm");
        mss           = CW'(2);
        ifg           = CW'(0);
        transfer_size = CW'(4);
        planTransfer(2, 0, 4, srcData);
        planTransfer(2, 0, 4, srcData + 64'd4);
        base = outBeats;
        @(negedge clk);
        continuous = 1'b1;
        n = 0;
        while ((expQ.size() > 2) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        continuous = 1'b0;
        waitDone("continuous", 100);
        checkOutput("continuousBeats", 64'(outBeats - base), 64'd8);
        watchIdle("continuousStop", 5);

        $display("[TB] reset mid-transfer");
        planTransfer(4, 3, 10, srcData);
        base = outBeats;
        applyStimulus(4, 3, 10);
        n = 0;
        while ((outBeats - base < 6) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("preResetBeats", 64'(outBeats - base), 64'd6);
        @(posedge clk);
        #2;
        compEn = 1'b0;
        arst   = 1'b0;
        #1;
        checkOutput("asyncValid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("asyncData", m_axis_tdata, 64'd0);
        checkOutput("asyncLast", 64'(m_axis_tlast), 64'd0);
        checkOutput("asyncReady", 64'(s_axis_tready), 64'd0);
        checkOutput("asyncBusy", 64'(busy), 64'd0);
        checkOutput("asyncFrag", 64'(frag_count), 64'd0);
        expQ.delete();
        repeat (3) @(negedge clk);
        arst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("postResetIdle", 64'(busy), 64'd0);
        prevStall = 1'b0;
        idleCount = 0;
        compEn    = 1'b1;
        planTransfer(4, 3, 10, srcData);
        base = outBeats;
        applyStimulus(4, 3, 10);
        waitDone("restart", 200);
        checkOutput("restartBeats", 64'(outBeats - base), 64'd10);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
